// File: rtl/ysyx_23060124_rst_seq.sv
// Reset sequencer: synchronises an asynchronous active-low reset and releases
// NUM_OUT per-domain resets in order, after a hold period, with a fixed gap
// between releases. A synchronous software request restarts the hold period.
module ysyx_23060124_rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_OUT     = 3,
    parameter int STRETCH     = 16,
    parameter int GAP         = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_sw_rst,
    output logic [NUM_OUT-1:0] o_rst_n,
    output logic               o_busy
);

    localparam int                IDX_W        = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [7:0]        STRETCH_LAST = 8'(STRETCH - 1);
    localparam logic [7:0]        GAP_LAST     = 8'(GAP - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   chain_out;
    logic                   active;

    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_OUT-1:0]     rst_q, rst_d;
    logic                   busy_q, busy_d;

    // Synchroniser chain: shifts ones in once the external reset is released.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign chain_out = sync_q[SYNC_STAGES-1];

    // The first edge that sees the chain high already counts as hold cycle 0,
    // so the sequencer is effectively running from that edge on.
    assign active = (state_q != ST_RESET) || chain_out;

    // Next-state logic: software restart has priority over sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        busy_d  = busy_q;
        if (active && i_sw_rst) begin
            state_d = ST_STRETCH;
            cnt_d   = 8'd0;
            idx_d   = '0;
            rst_d   = '0;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ST_RESET, ST_STRETCH: begin
                    if (active) begin
                        if (cnt_q == STRETCH_LAST) begin
                            rst_d[0] = 1'b1;
                            cnt_d    = 8'd0;
                            if (NUM_OUT == 1) begin
                                state_d = ST_RUN;
                                busy_d  = 1'b0;
                            end else begin
                                state_d = ST_RELEASE;
                                idx_d   = IDX_W'(1);
                            end
                        end else begin
                            state_d = ST_STRETCH;
                            cnt_d   = cnt_q + 8'd1;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        for (int k = 0; k < NUM_OUT; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                rst_d[k] = 1'b1;
                            end
                        end
                        cnt_d = 8'd0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                            busy_d  = 1'b0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end
    end

    // State, counters and output flops; outputs come straight from here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_RESET;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            rst_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
        end
    end

    assign o_rst_n = rst_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_ysyx_23060124_rst_seq.sv
// Bench for the reset sequencer: two instances (default and a minimal
// configuration) driven by shared directed + random stimulus and compared
// against a release-time model computed from edge counts.
module tb_ysyx_23060124_rst_seq;

    localparam int A_S = 2, A_N = 3, A_STR = 16, A_GAP = 4;
    localparam int B_S = 3, B_N = 1, B_STR = 1,  B_GAP = 4;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_sw_rst;
    logic [2:0] rst_a;
    logic       busy_a;
    logic [0:0] rst_b;
    logic       busy_b;

    int n_checks = 0;
    int n_fail   = 0;
    // Edges since reset release, and the reference edge the hold counts from.
    int ea, ra, eb, rb;

    always #5 clk = ~clk;

    ysyx_23060124_rst_seq #(
        .SYNC_STAGES(A_S), .NUM_OUT(A_N), .STRETCH(A_STR), .GAP(A_GAP)
    ) dut_a (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_sw_rst(i_sw_rst),
        .o_rst_n(rst_a), .o_busy(busy_a)
    );

    ysyx_23060124_rst_seq #(
        .SYNC_STAGES(B_S), .NUM_OUT(B_N), .STRETCH(B_STR), .GAP(B_GAP)
    ) dut_b (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_sw_rst(i_sw_rst),
        .o_rst_n(rst_b), .o_busy(busy_b)
    );

    // Bit i is released once STRETCH + i*GAP edges have elapsed past the reference.
    function automatic logic [7:0] model_rst(input int e, input int r, input int str,
                                             input int gap, input int n);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (e >= r + str + i * gap) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [7:0] model_busy(input logic [7:0] v, input int n);
        logic [7:0] mask;
        mask = 8'((1 << n) - 1);
        return {7'b0, (v != mask)};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] xa, xb;
        xa = model_rst(ea, ra, A_STR, A_GAP, A_N);
        xb = model_rst(eb, rb, B_STR, B_GAP, B_N);
        check({tag, "_a_rst"},  {5'b0, rst_a},  xa);
        check({tag, "_a_busy"}, {7'b0, busy_a}, model_busy(xa, A_N));
        check({tag, "_b_rst"},  {7'b0, rst_b},  xb);
        check({tag, "_b_busy"}, {7'b0, busy_b}, model_busy(xb, B_N));
        $display("t=%0t %s rst_n=%b sw=%b ea=%0d a=%b/%b eb=%0d b=%b/%b",
                 $time, tag, i_rst_n, i_sw_rst, ea, rst_a, busy_a, eb, rst_b, busy_b);
    endtask

    task automatic model_clear();
        ea = 0; ra = A_S;
        eb = 0; rb = B_S;
    endtask

    // One clock edge with the given software request, then check.
    task automatic clock_step(input string tag, input logic sw);
        i_sw_rst = sw;
        @(posedge clk);
        if (i_rst_n) begin
            ea++; eb++;
            // Requests are honoured only once the synchroniser output is high.
            if (sw && ea >= A_S + 1) ra = ea;
            if (sw && eb >= B_S + 1) rb = eb;
        end else begin
            model_clear();
        end
        #1;
        check_all(tag);
    endtask

    // Drop the external reset mid-cycle and confirm the asynchronous effect.
    task automatic async_drop(input string tag);
        #2 i_rst_n = 1'b0;
        model_clear();
        #1 check_all(tag);
    endtask

    task automatic short_pulse(input string tag);
        async_drop(tag);
        #1 i_rst_n = 1'b1;
    endtask

    initial begin
        int r;
        i_rst_n  = 1'b0;
        i_sw_rst = 1'b0;
        model_clear();

        // Power-on: held low for five cycles, then released.
        repeat (5) clock_step("por_low", 1'b0);
        i_rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            clock_step("por", 1'b0);
            if (k == 17) check("por_e17_directed", {5'b0, rst_a}, 8'b000);
            if (k == 18) check("por_e18_directed", {5'b0, rst_a}, 8'b001);
            if (k == 22) check("por_e22_directed", {5'b0, rst_a}, 8'b011);
            if (k == 26) check("por_e26_busy_directed", {7'b0, busy_a}, 8'd0);
        end

        // Asynchronous assertion while running, then a fresh release.
        async_drop("async_run");
        clock_step("async_low", 1'b0);
        clock_step("async_low", 1'b0);
        i_rst_n = 1'b1;
        repeat (30) clock_step("async_rel", 1'b0);

        // Single-cycle software reset while running.
        clock_step("sw_run_T", 1'b1);
        repeat (30) clock_step("sw_run", 1'b0);

        // Software reset mid-release (edge 20 after a fresh release).
        async_drop("mid_drop");
        clock_step("mid_low", 1'b0);
        i_rst_n = 1'b1;
        repeat (19) clock_step("mid_pre", 1'b0);
        clock_step("mid_T", 1'b1);
        check("mid_e20_directed", {5'b0, rst_a}, 8'b000);
        repeat (30) clock_step("mid_post", 1'b0);

        // Held request from edge 1 through edge 30, ignored while in reset.
        async_drop("held_drop");
        clock_step("held_low", 1'b0);
        i_rst_n = 1'b1;
        repeat (30) clock_step("held_sw", 1'b1);
        repeat (30) clock_step("held_rel", 1'b0);

        // Sub-cycle reset pulse while running.
        short_pulse("short_run");
        repeat (30) clock_step("short_rel", 1'b0);

        // Random mix of software requests, short pulses and held resets.
        for (int k = 0; k < 500; k++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                short_pulse("rnd_short");
                clock_step("rnd", 1'b0);
            end else if (r < 4) begin
                async_drop("rnd_drop");
                repeat ($urandom_range(1, 3)) clock_step("rnd_low", ($urandom_range(0, 1) == 1));
                i_rst_n = 1'b1;
            end else begin
                clock_step("rnd", (r < 10));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
